mode_stream_selector: RTL and testbench

- Registered, handshaked successor to the combinational mode input selector in the buffer/prefetcher path.
- Routes any of NCH valid/ready input channels onto two output lanes, each lane with its own DEPTH-entry FIFO buffer.
- Routing is a runtime mode (source index plus enable per lane) instead of a fixed 3-bit case table.
- Mode changes go through a drain-then-switch handshake, so no word in flight is ever re-routed or lost.

---
 rtl/mode_stream_selector.sv | 167 ++++++++++++++++
 tb/tb_mode_stream_selector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_stream_selector.sv
// Routes NCH valid/ready input channels onto two FIFO-buffered output lanes.
// Mode changes drain both lanes before the new routing takes effect.
module mode_stream_selector #(
  parameter int W     = 8,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int SW    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*W-1:0]         in_data,
  input  logic [NCH-1:0]           in_valid,
  output logic [NCH-1:0]           in_ready,
  input  logic                     mode_req,
  input  logic [SW-1:0]            mode_src1,
  input  logic [SW-1:0]            mode_src2,
  input  logic                     mode_en1,
  input  logic                     mode_en2,
  output logic                     mode_ack,
  output logic                     busy,
  output logic [W-1:0]             out1_data,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [W-1:0]             out2_data,
  output logic                     out2_valid,
  input  logic                     out2_ready,
  output logic [$clog2(DEPTH):0]   cnt1,
  output logic [$clog2(DEPTH):0]   cnt2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   src_q [2], src_d [2];
  logic [SW-1:0]   pend_src_q [2], pend_src_d [2];
  logic [1:0]      en_q, en_d, pend_en_q, pend_en_d;

  logic [W-1:0]    mem_q [2][DEPTH], mem_d [2][DEPTH];
  logic [PW-1:0]   rd_q [2], rd_d [2], wr_q [2], wr_d [2];
  logic [CW-1:0]   cnt_q [2], cnt_d [2];

  logic [1:0]      push, pop, lane_full;
  logic [W-1:0]    push_data [2];
  logic [NCH-1:0]  sel1, sel2;
  logic            both_empty;

  assign both_empty   = (cnt_q[0] == '0) && (cnt_q[1] == '0);
  assign lane_full[0] = (cnt_q[0] == CW'(DEPTH));
  assign lane_full[1] = (cnt_q[1] == CW'(DEPTH));

  // State register and mode/pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '{default: '0};
      pend_src_q <= '{default: '0};
      en_q       <= '0;
      pend_en_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pend_src_q <= pend_src_d;
      en_q       <= en_d;
      pend_en_q  <= pend_en_d;
    end
  end

  // Next-state: an out-of-range source is latched as a disabled lane
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    en_d       = en_q;
    pend_src_d = pend_src_q;
    pend_en_d  = pend_en_q;
    case (state_q)
      IDLE, RUN: begin
        if (mode_req) begin
          pend_src_d[0] = mode_src1;
          pend_src_d[1] = mode_src2;
          pend_en_d[0]  = mode_en1 && (int'(mode_src1) < NCH);
          pend_en_d[1]  = mode_en2 && (int'(mode_src2) < NCH);
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (both_empty) begin
          src_d   = pend_src_q;
          en_d    = pend_en_q;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready requires room in every lane sharing a channel (broadcast is all-or-nothing)
  always_comb begin
    in_ready  = '0;
    push      = '0;
    push_data = '{default: '0};
    sel1      = '0;
    sel2      = '0;
    busy      = (state_q == DRAIN);
    mode_ack  = (state_q == DRAIN) && both_empty;
    for (int unsigned k = 0; k < NCH; k++) begin
      sel1[k] = en_q[0] && (src_q[0] == SW'(k));
      sel2[k] = en_q[1] && (src_q[1] == SW'(k));
      if ((state_q == RUN) && (sel1[k] || sel2[k])) begin
        in_ready[k] = !(sel1[k] && lane_full[0]) && !(sel2[k] && lane_full[1]);
      end
      if (in_valid[k] && in_ready[k]) begin
        if (sel1[k]) begin
          push[0]      = 1'b1;
          push_data[0] = in_data[k*W +: W];
        end
        if (sel2[k]) begin
          push[1]      = 1'b1;
          push_data[1] = in_data[k*W +: W];
        end
      end
    end
    pop[0] = (cnt_q[0] != '0) && out1_ready;
    pop[1] = (cnt_q[1] != '0) && out2_ready;
  end

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    for (int unsigned l = 0; l < 2; l++) begin
      if (push[l]) begin
        mem_d[l][wr_q[l]] = push_data[l];
        wr_d[l]           = wr_q[l] + 1'b1;
      end
      if (pop[l]) begin
        rd_d[l] = rd_q[l] + 1'b1;
      end
      cnt_d[l] = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q  <= '{default: '0};
      wr_q  <= '{default: '0};
      cnt_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign out1_valid = (cnt_q[0] != '0);
  assign out2_valid = (cnt_q[1] != '0);
  assign out1_data  = out1_valid ? mem_q[0][rd_q[0]] : '0;
  assign out2_data  = out2_valid ? mem_q[1][rd_q[1]] : '0;
  assign cnt1       = cnt_q[0];
  assign cnt2       = cnt_q[1];

endmodule

// File: tb/tb_mode_stream_selector.sv
// Bench for mode_stream_selector: queue-based lane model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mode_stream_selector;

  localparam int W = 8, NCH = 4, DEPTH = 4, SW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode_req;
  logic [SW-1:0]    mode_src1, mode_src2;
  logic             mode_en1, mode_en2;
  logic             mode_ack, busy;
  logic [W-1:0]     out1_data, out2_data;
  logic             out1_valid, out2_valid;
  logic             out1_ready, out2_ready;
  logic [2:0]       cnt1, cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  mode_stream_selector #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode_req(mode_req), .mode_src1(mode_src1), .mode_src2(mode_src2),
    .mode_en1(mode_en1), .mode_en2(mode_en2), .mode_ack(mode_ack), .busy(busy),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane, flags for "mode applied" and "draining"
  logic [7:0] mq [2][$];
  bit         m_have, m_drain, model_live;
  bit         m_en [2], p_en [2];
  int         m_src [2], p_src [2];

  initial model_live = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    bit any, room;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      any  = 0;
      room = 1;
      for (int l = 0; l < 2; l++) begin
        if (m_en[l] && m_src[l] == k) begin
          any = 1;
          if (mq[l].size() >= DEPTH) room = 0;
        end
      end
      r[k] = m_have && !m_drain && any && room;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [3:0] rdy;
    bit         do_pop [2];
    bit         do_push [2];
    logic [7:0] pdat [2];
    bit         empty_both;
    if (rst) begin
      mq[0].delete();
      mq[1].delete();
      m_have = 0; m_drain = 0;
      for (int l = 0; l < 2; l++) begin
        m_en[l] = 0; p_en[l] = 0; m_src[l] = 0; p_src[l] = 0;
      end
      model_live = 1;
    end else if (model_live) begin
      rdy        = exp_ready();
      empty_both = (mq[0].size() == 0) && (mq[1].size() == 0);
      do_pop[0]  = (mq[0].size() != 0) && out1_ready;
      do_pop[1]  = (mq[1].size() != 0) && out2_ready;
      for (int l = 0; l < 2; l++) begin
        do_push[l] = 0;
        pdat[l]    = 8'h00;
        if (m_en[l] && in_valid[m_src[l]] && rdy[m_src[l]]) begin
          do_push[l] = 1;
          pdat[l]    = in_data[m_src[l]*8 +: 8];
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (do_pop[l]) void'(mq[l].pop_front());
        if (do_push[l]) mq[l].push_back(pdat[l]);
      end
      if (m_drain) begin
        if (empty_both) begin
          m_src = p_src; m_en = p_en;
          m_drain = 0; m_have = 1;
        end
      end else if (mode_req) begin
        p_src[0] = int'(mode_src1); p_en[0] = mode_en1 && (int'(mode_src1) < NCH);
        p_src[1] = int'(mode_src2); p_en[1] = mode_en2 && (int'(mode_src2) < NCH);
        m_drain = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("in_ready",   in_ready,   exp_ready());
      chk("out1_valid", out1_valid, mq[0].size() != 0);
      chk("out1_data",  out1_data,  mq[0].size() != 0 ? mq[0][0] : 8'h00);
      chk("cnt1",       cnt1,       mq[0].size());
      chk("out2_valid", out2_valid, mq[1].size() != 0);
      chk("out2_data",  out2_data,  mq[1].size() != 0 ? mq[1][0] : 8'h00);
      chk("cnt2",       cnt2,       mq[1].size());
      chk("busy",       busy,       m_drain);
      chk("mode_ack",   mode_ack,   m_drain && mq[0].size() == 0 && mq[1].size() == 0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int s1, input bit e1, input int s2, input bit e2);
    mode_src1 = SW'(s1); mode_en1 = e1;
    mode_src2 = SW'(s2); mode_en2 = e2;
    mode_req  = 1'b1;
    cycle();
    mode_req  = 1'b0;
  endtask

  task automatic wait_ack(input string nm);
    bit got = 0;
    for (int i = 0; i < 12; i++) begin
      if (mode_ack) begin
        got = 1;
        break;
      end
      cycle();
    end
    chk(nm, got, 1);
  endtask

  task automatic send(input int ch, input logic [7:0] v);
    bit done = 0;
    in_valid[ch]         = 1'b1;
    in_data[ch*8 +: 8]   = v;
    for (int i = 0; i < 12 && !done; i++) begin
      done = in_ready[ch];
      cycle();
    end
    in_valid[ch] = 1'b0;
    chk("send_accept", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, b;
    bit acc0, acc1, fin;
    rst = 1'b1; in_data = '0; in_valid = '0; mode_req = 1'b0;
    mode_src1 = '0; mode_src2 = '0; mode_en1 = 1'b0; mode_en2 = 1'b0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("idle_in_ready", in_ready, 4'b0000);
      chk("idle_valid", {out1_valid, out2_valid}, 2'b00);
      chk("idle_data", {out1_data, out2_data}, 16'h0000);
      chk("idle_ack", mode_ack, 0);
    end

    // Lane1 from channel 2 only
    req(2, 1, 0, 0);
    chk("ack_empty", mode_ack, 1);
    cycle();
    chk("ack_pulse_end", mode_ack, 0);
    chk("run_in_ready", in_ready, 4'b0100);
    out1_ready = 1'b1;
    send(2, 8'h0A); chk("l1_0A", out1_data, 8'h0A);
    send(2, 8'h0B); chk("l1_0B", out1_data, 8'h0B);
    send(2, 8'h0C); chk("l1_0C", out1_data, 8'h0C);
    chk("l2_idle", out2_valid, 0);
    cycle();
    chk("l1_empty_data", out1_data, 8'h00);

    // Two lanes, lane1 backpressured until full, then pointer wrap
    req(0, 1, 1, 1);
    wait_ack("ack_mode3");
    cycle();
    out1_ready = 1'b0; out2_ready = 1'b1;
    a = 0; b = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid[0] = (a < 6); in_data[7:0]  = 8'(16 + a);
      in_valid[1] = (b < 3); in_data[15:8] = 8'(32 + b);
      acc0 = in_valid[0] && in_ready[0];
      acc1 = in_valid[1] && in_ready[1];
      cycle();
      if (acc0) a++;
      if (acc1) b++;
    end
    chk("full_cnt1", cnt1, 4);
    chk("full_ready0", in_ready[0], 0);
    chk("full_head", out1_data, 8'h10);
    chk("lane2_flowed", b, 3);
    out1_ready = 1'b1;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      in_valid[0] = (a < 6); in_data[7:0] = 8'(16 + a);
      in_valid[1] = 1'b0;
      acc0 = in_valid[0] && in_ready[0];
      cycle();
      if (acc0) a++;
      fin = (a == 6) && !out1_valid && !out2_valid;
    end
    in_valid = '0;
    chk("wrap_done", fin, 1);

    // Drain-then-switch with a second request ignored
    out1_ready = 1'b0;
    send(0, 8'h31); send(0, 8'h32); send(0, 8'h33);
    chk("hold3", cnt1, 3);
    req(3, 1, 3, 1);
    chk("drain_busy", busy, 1);
    chk("drain_ready", in_ready, 4'b0000);
    chk("drain_noack", mode_ack, 0);
    req(1, 1, 1, 1);
    chk("drain_busy2", busy, 1);
    out1_ready = 1'b1;
    wait_ack("ack_after_drain");
    chk("ack_cnt1", cnt1, 0);
    cycle();
    chk("first_req_wins", in_ready, 4'b1000);
    out2_ready = 1'b1;
    send(3, 8'h5A);
    chk("bcast1", out1_data, 8'h5A);
    chk("bcast2", out2_data, 8'h5A);
    cycle();
    out2_ready = 1'b0;
    in_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!in_ready[3]) break;
      in_data[31:24] = 8'(64 + i);
      cycle();
    end
    in_valid[3] = 1'b0;
    chk("stall_cnt2", cnt2, 4);
    chk("stall_ready3", in_ready[3], 0);
    chk("lane1_room", cnt1 < 4, 1);

    // Out-of-range source disables lane1
    req(7, 1, 3, 1);
    out2_ready = 1'b1;
    wait_ack("ack_oor");
    cycle();
    chk("oor_ready", in_ready, 4'b1000);
    send(3, 8'h77);
    chk("oor_l2", out2_data, 8'h77);
    chk("oor_l1_valid", out1_valid, 0);
    chk("oor_cnt1", cnt1, 0);

    // Reset in DRAIN with partly full lanes
    req(0, 1, 1, 1);
    wait_ack("ack_pre_rst");
    cycle();
    out1_ready = 1'b0; out2_ready = 1'b0;
    send(0, 8'h61); send(0, 8'h62); send(1, 8'h71);
    req(2, 1, 2, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_cnt", {cnt1, cnt2}, 6'd0);
    chk("rst_valid", {out1_valid, out2_valid}, 2'b00);
    chk("rst_data", {out1_data, out2_data}, 16'h0000);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rst_noack", mode_ack, 0);
      chk("rst_idle_ready", in_ready, 4'b0000);
    end

    // Randomized traffic and mode changes
    for (int i = 0; i < 3000; i++) begin
      mode_req   = ($urandom_range(0, 19) == 0);
      mode_src1  = SW'($urandom_range(0, 7));
      mode_src2  = SW'($urandom_range(0, 7));
      mode_en1   = $urandom_range(0, 3) != 0;
      mode_en2   = $urandom_range(0, 3) != 0;
      in_valid   = 4'($urandom);
      in_data    = $urandom;
      out1_ready = $urandom_range(0, 3) != 0;
      out2_ready = $urandom_range(0, 3) != 0;
      rst        = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0; mode_req = 1'b0; in_valid = '0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
